// File: rtl/inst_fetch_if.sv
// Fetch-side bundle: instruction memory request/response, execute redirect and decode handshake.
// master = fetch unit, slave = the memory/execute/decode environment around it.
interface inst_fetch_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_inst;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_inst;
  logic [ADDR_WIDTH-1:0] out_pc;
  logic                  out_fault;

  modport master (
    output imem_addr,
    input  imem_inst,
    input  redirect_valid, redirect_pc,
    output out_valid, out_inst, out_pc, out_fault,
    input  out_ready
  );

  modport slave (
    input  imem_addr,
    output imem_inst,
    output redirect_valid, redirect_pc,
    input  out_valid, out_inst, out_pc, out_fault,
    output out_ready
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: PC owner for a 1-cycle-latency memory, 2-entry output buffer, redirect flush.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirects emit one fault entry and halt fetch.
module inst_fetch #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  inst_fetch_if.master bus
);
  typedef struct packed {
    logic [DATA_WIDTH-1:0] inst;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  fault;
  } entry_t;

  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

  logic [ADDR_WIDTH-1:0] pc_q, req_pc_q, redirect_tgt;
  logic                  pend_q, trap_q;
  entry_t                fifo_q [2];
  logic [1:0]            count_q;
  logic                  run, trap, pop, push, issue;
  logic [2:0]            occ;
  entry_t                din;

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic {RUN, HALT} state_t;
  state_t state_q, state_d;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;

  always_comb begin
    state_d = state_q;
    trap    = 1'b0;
    if (bus.redirect_valid) begin
      if (|bus.redirect_pc[1:0]) begin
        state_d = HALT;
        trap    = 1'b1;
      end else begin
        state_d = RUN;
      end
    end
  end

  assign run          = (state_q == RUN);
  assign redirect_tgt = bus.redirect_pc;
`else
  assign run          = 1'b1;
  assign trap         = 1'b0;
  assign redirect_tgt = bus.redirect_pc & ~ADDR_WIDTH'(3);
`endif

  // Occupancy counts buffered entries plus the response due this cycle.
  assign pop   = bus.out_valid & bus.out_ready;
  assign occ   = {1'b0, count_q} + {2'b0, pend_q} + {2'b0, trap_q};
  assign issue = run & ~bus.redirect_valid & (occ < (3'd2 + {2'b0, pop}));
  assign push  = ~bus.redirect_valid & (trap_q | (pend_q & run));
  assign din   = {(trap_q ? NOP : bus.imem_inst), req_pc_q, trap_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      pend_q   <= 1'b0;
      trap_q   <= 1'b0;
    end else begin
      trap_q <= trap;
      if (bus.redirect_valid) begin
        pc_q   <= redirect_tgt;
        pend_q <= 1'b0;
        if (trap) req_pc_q <= bus.redirect_pc;
      end else if (issue) begin
        req_pc_q <= pc_q;
        pc_q     <= pc_q + ADDR_WIDTH'(4);
        pend_q   <= 1'b1;
      end else begin
        pend_q <= 1'b0;
      end
    end
  end

  // Shift FIFO: entry 0 is always the head, so outputs are plain register reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
    end else if (bus.redirect_valid) begin
      count_q <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          fifo_q[count_q[0]] <= din;
          count_q            <= count_q + 2'd1;
        end
        2'b01: begin
          fifo_q[0] <= fifo_q[1];
          count_q   <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            fifo_q[0] <= din;
          end else begin
            fifo_q[0] <= fifo_q[1];
            fifo_q[1] <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.imem_addr = pc_q;
  assign bus.out_valid = (count_q != 2'd0);
  assign bus.out_inst  = fifo_q[0].inst;
  assign bus.out_pc    = fifo_q[0].pc;
  assign bus.out_fault = fifo_q[0].fault;
endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: reset, streaming, backpressure, redirects, misalign, mid-stream reset.
module tb_inst_fetch;
  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   fails   = 0;

  inst_fetch_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  inst_fetch #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'hA500_0000 ^ a;
  endfunction

  // Synchronous memory: data for the address seen at an edge appears after that edge.
  always @(posedge clk) bus.imem_inst <= word(bus.imem_addr);

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n              = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.out_ready      = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("rst_valid", 32'(bus.out_valid), 0);
    check("rst_inst",  bus.out_inst, 0);
    check("rst_pc",    bus.out_pc, 0);
    check("rst_fault", 32'(bus.out_fault), 0);
    check("rst_addr",  bus.imem_addr, 0);

    @(posedge clk); #1 rst_n = 1'b1;
    tick();
    check("first_valid_lo", 32'(bus.out_valid), 0);
    check("first_addr",     bus.imem_addr, 32'h4);
    tick();
    check("w0_valid", 32'(bus.out_valid), 1);
    check("w0_pc",    bus.out_pc, 32'h0);
    check("w0_inst",  bus.out_inst, word(32'h0));
    tick(); check("w1_pc", bus.out_pc, 32'h4); check("w1_inst", bus.out_inst, word(32'h4));
    tick(); check("w2_pc", bus.out_pc, 32'h8); check("w2_inst", bus.out_inst, word(32'h8));
    tick(); check("w3_pc", bus.out_pc, 32'hC); check("w3_inst", bus.out_inst, word(32'hC));

    // Backpressure: head holds, address stops advancing once two are buffered.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_pc", bus.out_pc, 32'hC);
    end
    check("bp_valid", 32'(bus.out_valid), 1);
    check("bp_addr",  bus.imem_addr, 32'h14);
    bus.out_ready = 1'b1;
    tick(); check("rel_pc0", bus.out_pc, 32'h10);
    tick(); check("rel_pc1", bus.out_pc, 32'h14);
    tick(); check("rel_pc2", bus.out_pc, 32'h18); check("rel_valid", 32'(bus.out_valid), 1);

    // Fill the FIFO, then redirect to 0x100.
    bus.out_ready = 1'b0;
    tick(); check("full_pc", bus.out_pc, 32'h18); check("full_addr", bus.imem_addr, 32'h20);
    tick();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h100;
    tick();
    bus.redirect_valid = 1'b0; bus.out_ready = 1'b1;
    check("rd_flush_valid", 32'(bus.out_valid), 0);
    check("rd_addr",        bus.imem_addr, 32'h100);
    tick(); check("rd_n2_valid", 32'(bus.out_valid), 0); check("rd_n2_addr", bus.imem_addr, 32'h104);
    tick();
    check("rd_n3_valid", 32'(bus.out_valid), 1);
    check("rd_n3_pc",    bus.out_pc, 32'h100);
    check("rd_n3_inst",  bus.out_inst, word(32'h100));

    // Redirect coinciding with pop and push.
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h300;
    tick();
    bus.redirect_valid = 1'b0;
    check("co_valid0", 32'(bus.out_valid), 0);
    check("co_addr",   bus.imem_addr, 32'h300);
    tick(); check("co_valid1", 32'(bus.out_valid), 0);
    tick(); check("co_valid2", 32'(bus.out_valid), 1); check("co_pc0", bus.out_pc, 32'h300);
    tick(); check("co_pc1", bus.out_pc, 32'h304);

    // Misaligned redirect.
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h102;
    tick();
    bus.redirect_valid = 1'b0;
    check("mis_flush_valid", 32'(bus.out_valid), 0);
    tick();
`ifdef FETCH_MISALIGN_TRAP_EN
    check("mis_trap_valid", 32'(bus.out_valid), 1);
    check("mis_trap_pc",    bus.out_pc, 32'h102);
    check("mis_trap_inst",  bus.out_inst, 32'h13);
    check("mis_trap_fault", 32'(bus.out_fault), 1);
`else
    check("mis_n2_valid", 32'(bus.out_valid), 0);
    check("mis_n2_addr",  bus.imem_addr, 32'h104);
`endif
    tick();
`ifdef FETCH_MISALIGN_TRAP_EN
    check("halt_valid", 32'(bus.out_valid), 0);
`else
    check("mis_valid", 32'(bus.out_valid), 1);
    check("mis_pc",    bus.out_pc, 32'h100);
    check("mis_fault", 32'(bus.out_fault), 0);
`endif
    repeat (3) tick();
`ifdef FETCH_MISALIGN_TRAP_EN
    check("halt_valid2", 32'(bus.out_valid), 0);
    check("halt_addr",   bus.imem_addr, 32'h102);
`else
    check("mis_pc3",    bus.out_pc, 32'h10C);
    check("mis_fault3", 32'(bus.out_fault), 0);
`endif
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h200;
    tick();
    bus.redirect_valid = 1'b0;
    tick();
    tick();
    check("res_valid", 32'(bus.out_valid), 1);
    check("res_pc",    bus.out_pc, 32'h200);
    tick(); check("res_pc1", bus.out_pc, 32'h204);

    // Asynchronous reset mid-stream.
    #1 rst_n = 1'b0;
    #1;
    check("mrst_valid", 32'(bus.out_valid), 0);
    check("mrst_inst",  bus.out_inst, 0);
    check("mrst_pc",    bus.out_pc, 0);
    check("mrst_addr",  bus.imem_addr, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    tick(); check("mrst_first_lo", 32'(bus.out_valid), 0);
    tick();
    check("mrst_w0_valid", 32'(bus.out_valid), 1);
    check("mrst_w0_pc",    bus.out_pc, 32'h0);
    check("mrst_w0_inst",  bus.out_inst, word(32'h0));
    tick(); check("mrst_w1_pc", bus.out_pc, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
